// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D$ request port among NrPorts requesters and routes in-order responses back by ID.
// Latency: a request accepted in cycle N is presented to the cache in cycle N+1; responses route back combinationally (0 cycles).
// Backpressure: the held request is frozen while mem_req_ready_i is low; req_ready_o drops while it is stuck or MaxOutstanding are in flight.
// Option: define DCACHE_ARB_PORT0_PRIO_EN to give port 0 strict priority over a round-robin among the remaining ports.
module dcache_port_arbiter #(
   parameter int NrPorts        = 3,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NrPorts-1:0]              req_valid_i,
   output logic [NrPorts-1:0]              req_ready_o,
   input  logic [NrPorts*AddrWidth-1:0]    req_addr_i,
   input  logic [NrPorts-1:0]              req_we_i,
   input  logic [NrPorts*DataWidth-1:0]    req_wdata_i,
   input  logic [NrPorts*DataWidth/8-1:0]  req_be_i,
   output logic                            mem_req_valid_o,
   input  logic                            mem_req_ready_i,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic                            mem_we_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   output logic [DataWidth/8-1:0]          mem_be_o,
   input  logic                            mem_rsp_valid_i,
   input  logic [DataWidth-1:0]            mem_rsp_rdata_i,
   output logic [NrPorts-1:0]              rsp_valid_o,
   output logic [DataWidth-1:0]            rsp_rdata_o,
   output logic                            spurious_rsp_o
);

   localparam int BeW  = DataWidth / 8;
   localparam int IdW  = $clog2(NrPorts);
   localparam int PtrW = $clog2(MaxOutstanding);
   localparam int CntW = PtrW + 1;

   // Output (cache request) register
   logic                 out_vld_q, out_vld_d;
   logic [AddrWidth-1:0] out_addr_q, out_addr_d;
   logic                 out_we_q, out_we_d;
   logic [DataWidth-1:0] out_wdata_q, out_wdata_d;
   logic [BeW-1:0]       out_be_q, out_be_d;
   logic [IdW-1:0]       out_id_q, out_id_d;

   // Arbitration pointer
   logic [IdW-1:0]       last_grant_q, last_grant_d;

   // In-order ID FIFO of requests already handed to the cache
   logic [MaxOutstanding-1:0][IdW-1:0] fifo_q, fifo_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   // Combinational control
   logic [CntW-1:0]      outstanding;
   logic                 can_accept;
   logic                 win_found;
   logic [IdW-1:0]       win_id;
   logic [AddrWidth-1:0] win_addr;
   logic                 win_we;
   logic [DataWidth-1:0] win_wdata;
   logic [BeW-1:0]       win_be;
   logic                 accept;
   logic                 push;
   logic                 pop;

   // Slot accounting uses registered state only; a same-cycle pop never frees a slot.
   assign outstanding = cnt_q + CntW'(out_vld_q);
   assign can_accept  = rst_ni && (!out_vld_q || mem_req_ready_i)
                        && (outstanding < CntW'(MaxOutstanding));
   assign accept      = win_found && can_accept;
   assign push        = out_vld_q && mem_req_ready_i;
   assign pop         = mem_rsp_valid_i && (cnt_q != '0);

   // Winner search starting after the last granted port; also muxes the winner's fields.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      win_addr  = '0;
      win_we    = 1'b0;
      win_wdata = '0;
      win_be    = '0;
`ifdef DCACHE_ARB_PORT0_PRIO_EN
      if (req_valid_i[0]) begin
         win_found = 1'b1;
         win_id    = '0;
         win_addr  = req_addr_i[0 +: AddrWidth];
         win_we    = req_we_i[0];
         win_wdata = req_wdata_i[0 +: DataWidth];
         win_be    = req_be_i[0 +: BeW];
      end else begin
         // Ports 1..NrPorts-1 rotate among themselves; last_grant never points at port 0 here.
         for (int k = 1; k < NrPorts; k++) begin
            idx = ((int'(last_grant_q) - 1 + k) % (NrPorts - 1)) + 1;
            if (!win_found && req_valid_i[idx]) begin
               win_found = 1'b1;
               win_id    = IdW'(idx);
               win_addr  = req_addr_i[idx*AddrWidth +: AddrWidth];
               win_we    = req_we_i[idx];
               win_wdata = req_wdata_i[idx*DataWidth +: DataWidth];
               win_be    = req_be_i[idx*BeW +: BeW];
            end
         end
      end
`else
      for (int k = 1; k <= NrPorts; k++) begin
         idx = (int'(last_grant_q) + k) % NrPorts;
         if (!win_found && req_valid_i[idx]) begin
            win_found = 1'b1;
            win_id    = IdW'(idx);
            win_addr  = req_addr_i[idx*AddrWidth +: AddrWidth];
            win_we    = req_we_i[idx];
            win_wdata = req_wdata_i[idx*DataWidth +: DataWidth];
            win_be    = req_be_i[idx*BeW +: BeW];
         end
      end
`endif
   end

   // Only the winner sees ready, and only when a slot and the output register are free.
   always_comb begin
      req_ready_o = '0;
      if (win_found) begin
         req_ready_o[win_id] = can_accept;
      end
   end

   // Next state: load on accept, clear on handshake, push/pop the ID FIFO.
   always_comb begin
      out_vld_d    = out_vld_q;
      out_addr_d   = out_addr_q;
      out_we_d     = out_we_q;
      out_wdata_d  = out_wdata_q;
      out_be_d     = out_be_q;
      out_id_d     = out_id_q;
      last_grant_d = last_grant_q;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;

      if (accept) begin
         out_vld_d   = 1'b1;
         out_addr_d  = win_addr;
         out_we_d    = win_we;
         out_wdata_d = win_wdata;
         out_be_d    = win_be;
         out_id_d    = win_id;
`ifdef DCACHE_ARB_PORT0_PRIO_EN
         if (win_id != '0) begin
            last_grant_d = win_id;
         end
`else
         last_grant_d = win_id;
`endif
      end else if (push) begin
         out_vld_d = 1'b0;
      end

      if (push) begin
         fifo_d[wr_ptr_q] = out_id_q;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
   end

   // State registers; reset drops the held request and all outstanding IDs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_vld_q    <= 1'b0;
         out_addr_q   <= '0;
         out_we_q     <= 1'b0;
         out_wdata_q  <= '0;
         out_be_q     <= '0;
         out_id_q     <= '0;
         last_grant_q <= IdW'(NrPorts - 1);
         fifo_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         out_vld_q    <= out_vld_d;
         out_addr_q   <= out_addr_d;
         out_we_q     <= out_we_d;
         out_wdata_q  <= out_wdata_d;
         out_be_q     <= out_be_d;
         out_id_q     <= out_id_d;
         last_grant_q <= last_grant_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   assign mem_req_valid_o = out_vld_q;
   assign mem_addr_o      = out_addr_q;
   assign mem_we_o        = out_we_q;
   assign mem_wdata_o     = out_wdata_q;
   assign mem_be_o        = out_be_q;

   // Response routing: one-hot strobe to the FIFO head owner in the same cycle.
   always_comb begin
      rsp_valid_o = '0;
      if (pop) begin
         rsp_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
      end
   end

   assign rsp_rdata_o    = mem_rsp_rdata_i;
   // Judged on the registered count, so a response racing the first push is still spurious.
   assign spurious_rsp_o = rst_ni && mem_rsp_valid_i && (cnt_q == '0);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
// Latency: model expects cache request one cycle after accept and same-cycle response routing.
// Backpressure: random mem_req_ready_i stalls; model tracks the held request and ID order.
module tb_dcache_port_arbiter;
   localparam int N    = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [N-1:0]      req_valid_i;
   logic [N-1:0]      req_ready_o;
   logic [N*AW-1:0]   req_addr_i;
   logic [N-1:0]      req_we_i;
   logic [N*DW-1:0]   req_wdata_i;
   logic [N*BW-1:0]   req_be_i;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [AW-1:0]     mem_addr_o;
   logic              mem_we_o;
   logic [DW-1:0]     mem_wdata_o;
   logic [BW-1:0]     mem_be_o;
   logic              mem_rsp_valid_i;
   logic [DW-1:0]     mem_rsp_rdata_i;
   logic [N-1:0]      rsp_valid_o;
   logic [DW-1:0]     rsp_rdata_o;
   logic              spurious_rsp_o;

   dcache_port_arbiter #(
      .NrPorts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i),
      .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .spurious_rsp_o(spurious_rsp_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int            m_last;
   int            idq[$];
   logic          m_vld;
   logic [AW-1:0] m_addr;
   logic          m_we;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_be;
   int            m_id;
   int            obs_grant;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last = N - 1;
      idq.delete();
      m_vld = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_be = '0; m_id = 0;
   endtask

   // Round-robin (or port-0-priority) pick from the current valids, -1 if none.
   function automatic int pick_winner();
      int w;
      int p;
      w = -1;
`ifdef DCACHE_ARB_PORT0_PRIO_EN
      if (req_valid_i[0]) return 0;
      for (int k = 1; k < N; k++) begin
         p = ((m_last - 1 + k) % (N - 1)) + 1;
         if (w < 0 && req_valid_i[p]) w = p;
      end
`else
      for (int k = 1; k <= N; k++) begin
         p = (m_last + k) % N;
         if (w < 0 && req_valid_i[p]) w = p;
      end
`endif
      return w;
   endfunction

   task automatic idle();
      req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0; req_be_i = '0;
      mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
      req_addr_i[p*AW +: AW]  = a;
      req_we_i[p]             = we;
      req_wdata_i[p*DW +: DW] = d;
      req_be_i[p*BW +: BW]    = be;
   endtask

   task automatic rand_ports();
      for (int p = 0; p < N; p++) set_port(p, $urandom, 1'($urandom), $urandom, BW'($urandom));
   endtask

   // Called just after a negedge with inputs set: checks all outputs, then advances the model at posedge.
   task automatic cycle();
      int outst;
      int w;
      logic can;
      logic pop;
      logic [N-1:0] e_rdy;
      logic [N-1:0] e_rsp;
      #1;
      check_eq("mem_vld", mem_req_valid_o, m_vld);
      if (m_vld) begin
         check_eq("mem_addr", mem_addr_o, m_addr);
         check_eq("mem_we", mem_we_o, m_we);
         check_eq("mem_wdata", mem_wdata_o, m_wdata);
         check_eq("mem_be", mem_be_o, m_be);
      end
      outst = idq.size() + int'(m_vld);
      can   = (!m_vld || mem_req_ready_i) && (outst < MAXO);
      w     = pick_winner();
      e_rdy = '0;
      if (w >= 0 && can) e_rdy[w] = 1'b1;
      check_eq("req_rdy", req_ready_o, e_rdy);
      pop   = mem_rsp_valid_i && (idq.size() > 0);
      e_rsp = '0;
      if (pop) e_rsp[idq[0]] = 1'b1;
      check_eq("rsp_vld", rsp_valid_o, e_rsp);
      check_eq("spurious", spurious_rsp_o, mem_rsp_valid_i && (idq.size() == 0));
      if (pop) check_eq("rsp_dat", rsp_rdata_o, mem_rsp_rdata_i);
      obs_grant = -1;
      for (int i = 0; i < N; i++) if (req_ready_o[i] && req_valid_i[i]) obs_grant = i;
      @(posedge clk_i);
      if (pop) void'(idq.pop_front());
      if (m_vld && mem_req_ready_i) idq.push_back(m_id);
      if (w >= 0 && can) begin
         m_vld   = 1'b1;
         m_addr  = req_addr_i[w*AW +: AW];
         m_we    = req_we_i[w];
         m_wdata = req_wdata_i[w*DW +: DW];
         m_be    = req_be_i[w*BW +: BW];
         m_id    = w;
`ifdef DCACHE_ARB_PORT0_PRIO_EN
         if (w != 0) m_last = w;
`else
         m_last = w;
`endif
      end else if (m_vld && mem_req_ready_i) begin
         m_vld = 1'b0;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      idle();
      req_valid_i = '1;
      mem_rsp_valid_i = 1'b1;
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      check_eq("rst_mem_vld", mem_req_valid_o, 1'b0);
      check_eq("rst_mem_addr", mem_addr_o, '0);
      check_eq("rst_mem_we", mem_we_o, 1'b0);
      check_eq("rst_mem_wdata", mem_wdata_o, '0);
      check_eq("rst_mem_be", mem_be_o, '0);
      check_eq("rst_req_rdy", req_ready_o, '0);
      check_eq("rst_rsp_vld", rsp_valid_o, '0);
      check_eq("rst_spurious", spurious_rsp_o, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle();
      model_reset();
   endtask

   // Return every outstanding response, bounded so a broken model cannot stall the run.
   task automatic drain();
      int budget;
      budget = 0;
      req_valid_i = '0;
      mem_req_ready_i = 1'b1;
      while ((idq.size() > 0 || m_vld) && budget < 20) begin
         mem_rsp_valid_i = (idq.size() > 0);
         mem_rsp_rdata_i = $urandom;
         cycle();
         budget++;
      end
      mem_rsp_valid_i = 1'b0;
      if (budget >= 20) check_eq("drain_timeout", 1'b1, 1'b0);
   endtask

   int exp_order[9] = '{0, 1, 2, 0, 1, 2, 1, 2, 1};
   logic [AW-1:0] held_addr;
   logic [DW-1:0] held_wdata;
   logic [BW-1:0] held_be;

   initial begin
      idle();
      model_reset();
      do_reset();

      // Round-robin with all ports valid, then port 0 drops.
      for (int i = 0; i < 9; i++) begin
`ifdef DCACHE_ARB_PORT0_PRIO_EN
         if (i < 6) exp_order[i] = 0;
`endif
         req_valid_i = (i < 6) ? 3'b111 : 3'b110;
         mem_req_ready_i = 1'b1;
         rand_ports();
         mem_rsp_valid_i = (idq.size() > 0);
         mem_rsp_rdata_i = $urandom;
         cycle();
         check_eq("rr_order", obs_grant, exp_order[i]);
      end
      drain();

      // Single port: port 1 read at 0x100, response 0xDEADBEEF.
      do_reset();
      set_port(1, 32'h100, 1'b0, 32'h0, 4'hF);
      req_valid_i = 3'b010;
      cycle();
      check_eq("sp_grant", obs_grant, 1);
      req_valid_i = '0;
      check_eq("sp_mem_vld", mem_req_valid_o, 1'b1);
      check_eq("sp_mem_addr", mem_addr_o, 32'h100);
      cycle();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'hDEADBEEF;
      #1;
      check_eq("sp_rsp_vld", rsp_valid_o, 3'b010);
      check_eq("sp_rsp_dat", rsp_rdata_o, 32'hDEADBEEF);
      cycle();
      mem_rsp_valid_i = 1'b0;

      // Ordering: ports 2,0,1 issue; responses back-to-back with a push/pop overlap.
      for (int c = 0; c < 6; c++) begin
         rand_ports();
         req_valid_i = (c == 0) ? 3'b100 : (c == 1) ? 3'b001 : (c == 2) ? 3'b010 : 3'b000;
         mem_rsp_valid_i = (c >= 3);
         mem_rsp_rdata_i = 32'hA0 + DW'(c);
         #1;
         if (c == 3) check_eq("ord_rsp_a", rsp_valid_o, 3'b100);
         if (c == 4) check_eq("ord_rsp_b", rsp_valid_o, 3'b001);
         if (c == 5) check_eq("ord_rsp_c", rsp_valid_o, 3'b010);
         cycle();
      end
      mem_rsp_valid_i = 1'b0;
      drain();

      // Backpressure: cache stalls 5 cycles; held request must not move.
      for (int c = 0; c < 6; c++) begin
         rand_ports();
         req_valid_i = 3'b001;
         mem_req_ready_i = 1'b0;
         if (c == 0) begin
            held_addr  = req_addr_i[0 +: AW];
            held_wdata = req_wdata_i[0 +: DW];
            held_be    = req_be_i[0 +: BW];
         end
         #1;
         if (c > 0) begin
            check_eq("bp_rdy", req_ready_o, '0);
            check_eq("bp_addr", mem_addr_o, held_addr);
            check_eq("bp_wdata", mem_wdata_o, held_wdata);
            check_eq("bp_be", mem_be_o, held_be);
         end
         cycle();
      end
      drain();

      // Full: 4 in flight blocks accepts until one response frees exactly one slot.
      for (int c = 0; c < 9; c++) begin
         rand_ports();
         req_valid_i = '1;
         mem_req_ready_i = 1'b1;
         mem_rsp_valid_i = (c == 6);
         mem_rsp_rdata_i = $urandom;
         #1;
         if (c == 4 || c == 5 || c == 6 || c == 8) check_eq("full_rdy", req_ready_o, '0);
         if (c == 7) check_eq("full_one_acc", $countones(req_ready_o), 1);
         cycle();
      end
      drain();

      // Spurious response with nothing outstanding, then a one-cycle pulse only.
      mem_rsp_valid_i = 1'b1;
      #1;
      check_eq("spur_pulse", spurious_rsp_o, 1'b1);
      check_eq("spur_no_rsp", rsp_valid_o, '0);
      cycle();
      mem_rsp_valid_i = 1'b0;
      #1;
      check_eq("spur_end", spurious_rsp_o, 1'b0);
      cycle();

      // Reset with requests in flight discards them; later responses are spurious.
      for (int c = 0; c < 3; c++) begin
         rand_ports();
         req_valid_i = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100;
         cycle();
      end
      do_reset();
      mem_rsp_valid_i = 1'b1;
      #1;
      check_eq("post_rst_spur", spurious_rsp_o, 1'b1);
      check_eq("post_rst_rsp", rsp_valid_o, '0);
      cycle();
      mem_rsp_valid_i = 1'b0;

      // Random traffic with random stalls and occasional stray responses.
      for (int c = 0; c < 3000; c++) begin
         rand_ports();
         for (int p = 0; p < N; p++) req_valid_i[p] = ($urandom_range(0, 99) < 60);
         mem_req_ready_i = ($urandom_range(0, 99) < 70);
         mem_rsp_valid_i = (idq.size() > 0) ? ($urandom_range(0, 99) < 45)
                                            : ($urandom_range(0, 99) < 3);
         mem_rsp_rdata_i = $urandom;
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
